// File: rtl/sfifo_flags_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sfifo_flags_if : producer/consumer signal bundle for the sfifo_flags FIFO  |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
interface sfifo_flags_if #(
    parameter int BW     = 8,
    parameter int LGFLEN = 4
);
    logic              i_flush;
    logic              i_clr_err;
    logic              i_wr;
    logic [BW-1:0]     i_data;
    logic              i_rd;
    logic              o_full;
    logic              o_afull;
    logic [LGFLEN:0]   o_fill;
    logic [BW-1:0]     o_data;
    logic              o_valid;
    logic              o_empty;
    logic              o_aempty;
    logic              o_overflow;
    logic              o_underflow;

    modport master (
        output i_flush, i_clr_err, i_wr, i_data, i_rd,
        input  o_full, o_afull, o_fill, o_data, o_valid, o_empty, o_aempty,
               o_overflow, o_underflow
    );

    modport slave (
        input  i_flush, i_clr_err, i_wr, i_data, i_rd,
        output o_full, o_afull, o_fill, o_data, o_valid, o_empty, o_aempty,
               o_overflow, o_underflow
    );
endinterface
`default_nettype wire

// File: rtl/sfifo_flags.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sfifo_flags : single-clock FIFO with flush, almost flags, FWFT/registered  |
// |               read and sticky overflow/underflow flags                     |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module sfifo_flags #(
    parameter int BW         = 8,
    parameter int LGFLEN     = 4,
    parameter int AF_LEVEL   = 12,
    parameter int AE_LEVEL   = 2,
    parameter int OPT_FWFT   = 1,
    parameter int OPT_WRFULL = 1
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    sfifo_flags_if.slave  bus
);
    localparam int              c_DEPTH   = 1 << LGFLEN;
    localparam logic [LGFLEN:0] c_DEPTH_W = c_DEPTH[LGFLEN:0];
    localparam logic [LGFLEN:0] c_AF      = AF_LEVEL[LGFLEN:0];
    localparam logic [LGFLEN:0] c_AE      = AE_LEVEL[LGFLEN:0];
    localparam logic [LGFLEN:0] c_ONE     = (LGFLEN+1)'(1);

    logic [BW-1:0]   mem_q [c_DEPTH];
    logic [LGFLEN:0] wr_addr_q, rd_addr_q, fill_q, fill_d;
    logic            full_q, afull_q, empty_q, aempty_q;
    logic            overflow_q, underflow_q;

    logic            w_rd_ok, w_wr_ok, w_rd_go, w_wr_go, w_ovf_set, w_unf_set;
    logic [LGFLEN-1:0] w_rd_idx;

    assign w_rd_ok  = bus.i_rd & ~empty_q;
    assign w_wr_ok  = bus.i_wr & (~full_q | ((OPT_WRFULL != 0) & w_rd_ok));
    // A flush swallows same-cycle traffic entirely, including its error side effects.
    assign w_rd_go   = w_rd_ok & ~bus.i_flush;
    assign w_wr_go   = w_wr_ok & ~bus.i_flush;
    assign w_ovf_set = bus.i_wr & ~w_wr_ok & ~bus.i_flush;
    assign w_unf_set = bus.i_rd & empty_q & ~bus.i_flush;
    assign w_rd_idx  = rd_addr_q[LGFLEN-1:0];

    always_comb begin
        fill_d = fill_q;
        if (bus.i_flush)
            fill_d = '0;
        else if (w_wr_go && !w_rd_go)
            fill_d = fill_q + c_ONE;
        else if (!w_wr_go && w_rd_go)
            fill_d = fill_q - c_ONE;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_addr_q   <= '0;
            rd_addr_q   <= '0;
            fill_q      <= '0;
            full_q      <= 1'b0;
            afull_q     <= 1'b0;
            empty_q     <= 1'b1;
            aempty_q    <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (bus.i_flush) begin
                wr_addr_q <= '0;
                rd_addr_q <= '0;
            end else begin
                if (w_wr_go) wr_addr_q <= wr_addr_q + c_ONE;
                if (w_rd_go) rd_addr_q <= rd_addr_q + c_ONE;
            end
            fill_q   <= fill_d;
            full_q   <= (fill_d == c_DEPTH_W);
            afull_q  <= (fill_d >= c_AF);
            empty_q  <= (fill_d == '0);
            aempty_q <= (fill_d <= c_AE);
            // Setting beats clearing so an error in the clear cycle is never lost.
            if (w_ovf_set)          overflow_q <= 1'b1;
            else if (bus.i_clr_err) overflow_q <= 1'b0;
            if (w_unf_set)          underflow_q <= 1'b1;
            else if (bus.i_clr_err) underflow_q <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr_go)
            mem_q[wr_addr_q[LGFLEN-1:0]] <= bus.i_data;
    end

    generate
        if (OPT_FWFT != 0) begin : g_fwft
            assign bus.o_data  = mem_q[w_rd_idx];
            assign bus.o_valid = ~empty_q;
        end else begin : g_reg
            logic [BW-1:0] rdata_q;
            logic          valid_q;
            always_ff @(posedge i_clk or negedge i_reset_n) begin
                if (!i_reset_n) begin
                    rdata_q <= '0;
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= w_rd_go;
                    if (w_rd_go)
                        rdata_q <= mem_q[w_rd_idx];
                end
            end
            assign bus.o_data  = rdata_q;
            assign bus.o_valid = valid_q;
        end
    endgenerate

    assign bus.o_fill      = fill_q;
    assign bus.o_full      = full_q;
    assign bus.o_afull     = afull_q;
    assign bus.o_empty     = empty_q;
    assign bus.o_aempty    = aempty_q;
    assign bus.o_overflow  = overflow_q;
    assign bus.o_underflow = underflow_q;
endmodule
`default_nettype wire

// File: tb/tb_sfifo_flags.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sfifo_flags : vector table + data scoreboard bench for sfifo_flags      |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_sfifo_flags;
    localparam int BW = 8, LGFLEN = 2, D = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    int              sel;
    logic            wr, rd, fl, clr;
    logic [BW-1:0]   din;
    logic [BW-1:0]   dout;
    logic [LGFLEN:0] fill;
    logic            full, afull, empty, aempty, ovf, unf, vld;

    sfifo_flags_if #(.BW(BW), .LGFLEN(LGFLEN)) if0 ();
    sfifo_flags_if #(.BW(BW), .LGFLEN(LGFLEN)) if1 ();
    sfifo_flags_if #(.BW(BW), .LGFLEN(LGFLEN)) if2 ();

    assign if0.i_wr = wr & (sel == 0);  assign if0.i_rd = rd & (sel == 0);
    assign if0.i_flush = fl & (sel == 0); assign if0.i_clr_err = clr & (sel == 0);
    assign if0.i_data = din;
    assign if1.i_wr = wr & (sel == 1);  assign if1.i_rd = rd & (sel == 1);
    assign if1.i_flush = fl & (sel == 1); assign if1.i_clr_err = clr & (sel == 1);
    assign if1.i_data = din;
    assign if2.i_wr = wr & (sel == 2);  assign if2.i_rd = rd & (sel == 2);
    assign if2.i_flush = fl & (sel == 2); assign if2.i_clr_err = clr & (sel == 2);
    assign if2.i_data = din;

    sfifo_flags #(.BW(BW), .LGFLEN(LGFLEN), .AF_LEVEL(3), .AE_LEVEL(1), .OPT_FWFT(1), .OPT_WRFULL(1))
        u_fwft (.i_clk(clk), .i_reset_n(rst_n), .bus(if0));
    sfifo_flags #(.BW(BW), .LGFLEN(LGFLEN), .AF_LEVEL(3), .AE_LEVEL(1), .OPT_FWFT(1), .OPT_WRFULL(0))
        u_nowf (.i_clk(clk), .i_reset_n(rst_n), .bus(if1));
    sfifo_flags #(.BW(BW), .LGFLEN(LGFLEN), .AF_LEVEL(3), .AE_LEVEL(1), .OPT_FWFT(0), .OPT_WRFULL(1))
        u_reg  (.i_clk(clk), .i_reset_n(rst_n), .bus(if2));

    always_comb begin
        case (sel)
            1: begin dout = if1.o_data; fill = if1.o_fill; full = if1.o_full; afull = if1.o_afull;
                     empty = if1.o_empty; aempty = if1.o_aempty; ovf = if1.o_overflow;
                     unf = if1.o_underflow; vld = if1.o_valid; end
            2: begin dout = if2.o_data; fill = if2.o_fill; full = if2.o_full; afull = if2.o_afull;
                     empty = if2.o_empty; aempty = if2.o_aempty; ovf = if2.o_overflow;
                     unf = if2.o_underflow; vld = if2.o_valid; end
            default: begin dout = if0.o_data; fill = if0.o_fill; full = if0.o_full; afull = if0.o_afull;
                     empty = if0.o_empty; aempty = if0.o_aempty; ovf = if0.o_overflow;
                     unf = if0.o_underflow; vld = if0.o_valid; end
        endcase
    end

    // Flags packed as {full, afull, empty, aempty, overflow, underflow}.
    typedef struct {
        logic wr, rd, fl, clr;
        logic [7:0] d;
        logic [2:0] fill;
        logic [5:0] flags;
    } vec_t;

    vec_t          vecs[$];
    logic [BW-1:0] sb[$];
    int            checks = 0;
    int            errors = 0;

    function automatic void add(logic w, logic r, logic f, logic c, logic [7:0] d,
                                logic [2:0] fi, logic [5:0] fg);
        vec_t v;
        v.wr = w; v.rd = r; v.fl = f; v.clr = c; v.d = d; v.fill = fi; v.flags = fg;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
        wr = 1'b0; rd = 1'b0; fl = 1'b0; clr = 1'b0;
    endtask

    task automatic chk_state(input string tag, input logic [2:0] f, input logic [5:0] fg);
        check({tag, " fill"}, 32'(fill), 32'(f));
        check({tag, " flags"}, 32'({full, afull, empty, aempty, ovf, unf}), 32'(fg));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [BW-1:0] exp;
        logic          rdacc;
        sel = 0; wr = 0; rd = 0; fl = 0; clr = 0; din = '0;
        rst_n = 1'b0;

        // T2/T3 fill, overflow, FWFT drain, underflow, clear
        add(1,0,0,0,8'h11,1,6'b000100); add(1,0,0,0,8'h22,2,6'b000000);
        add(1,0,0,0,8'h33,3,6'b010000); add(1,0,0,0,8'h44,4,6'b110000);
        add(1,0,0,0,8'h55,4,6'b110010);
        add(0,1,0,0,8'h00,3,6'b010010); add(0,1,0,0,8'h00,2,6'b000010);
        add(0,1,0,0,8'h00,1,6'b000110); add(0,1,0,0,8'h00,0,6'b001110);
        add(0,1,0,0,8'h00,0,6'b001111); add(0,0,0,1,8'h00,0,6'b001100);
        // T4 full with read+write, then empty with read+write
        add(1,0,0,0,8'h01,1,6'b000100); add(1,0,0,0,8'h02,2,6'b000000);
        add(1,0,0,0,8'h03,3,6'b010000); add(1,0,0,0,8'h04,4,6'b110000);
        add(1,1,0,0,8'hAA,4,6'b110000);
        add(0,1,0,0,8'h00,3,6'b010000); add(0,1,0,0,8'h00,2,6'b000000);
        add(0,1,0,0,8'h00,1,6'b000100); add(0,1,0,0,8'h00,0,6'b001100);
        add(1,1,0,0,8'h77,1,6'b000101); add(0,1,0,0,8'h00,0,6'b001101);
        add(0,0,0,1,8'h00,0,6'b001100);
        // T6 flush with same-cycle write, then fresh traffic
        add(1,0,0,0,8'hB1,1,6'b000100); add(1,0,0,0,8'hB2,2,6'b000000);
        add(1,0,0,0,8'hB3,3,6'b010000); add(1,0,1,0,8'hEE,0,6'b001100);
        add(1,0,0,0,8'hC1,1,6'b000100); add(0,1,0,0,8'h00,0,6'b001100);

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk_state("reset", 3'd0, 6'b001100);
        check("reset reg valid", 32'(if2.o_valid), 32'd0);
        check("reset reg data", 32'(if2.o_data), 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // T1 asynchronous reset mid-stream
        for (int k = 0; k < 3; k++) begin
            wr = 1'b1; din = 8'(8'hD0 + k);
            tick();
        end
        chk_state("t1 pre", 3'd3, 6'b010000);
        #2 rst_n = 1'b0;
        #1;
        chk_state("t1 async", 3'd0, 6'b001100);
        check("t1 valid", 32'(vld), 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // Table-driven vectors on the FWFT instance
        sel = 0;
        sb.delete();
        for (int i = 0; i < vecs.size(); i++) begin
            wr = vecs[i].wr; rd = vecs[i].rd; fl = vecs[i].fl; clr = vecs[i].clr; din = vecs[i].d;
            #1;
            rdacc = rd && !fl && (sb.size() > 0);
            if (rdacc) begin
                exp = sb.pop_front();
                check($sformatf("v%0d fwft data", i), 32'(dout), 32'(exp));
                check($sformatf("v%0d fwft valid", i), 32'(vld), 32'd1);
            end
            if (fl) sb.delete();
            else if (wr && sb.size() < D) sb.push_back(din);
            tick();
            chk_state($sformatf("v%0d", i), vecs[i].fill, vecs[i].flags);
        end

        // T4 without write-through on full
        sel = 1;
        for (int k = 0; k < 4; k++) begin
            wr = 1'b1; din = 8'(8'h10 + k);
            tick();
        end
        chk_state("nowf full", 3'd4, 6'b110000);
        wr = 1'b1; rd = 1'b1; din = 8'hAA;
        #1;
        check("nowf head", 32'(dout), 32'h10);
        tick();
        chk_state("nowf rdwr", 3'd3, 6'b010010);
        for (int k = 0; k < 3; k++) begin
            rd = 1'b1;
            #1;
            check($sformatf("nowf drain%0d", k), 32'(dout), 32'(8'h11 + k));
            tick();
        end
        chk_state("nowf empty", 3'd0, 6'b001110);

        // T5 registered read: latency and pointer wrap
        sel = 2;
        check("reg idle valid", 32'(vld), 32'd0);
        wr = 1'b1; din = 8'h5A;
        tick();
        rd = 1'b1;
        tick();
        check("reg valid", 32'(vld), 32'd1);
        check("reg data", 32'(dout), 32'h5A);
        tick();
        check("reg valid drop", 32'(vld), 32'd0);
        check("reg data hold", 32'(dout), 32'h5A);
        sb.delete();
        wr = 1'b1; din = 8'h60; sb.push_back(din);
        tick();
        for (int i = 1; i <= 10; i++) begin
            wr = 1'b1; rd = 1'b1; din = 8'(8'h60 + i);
            sb.push_back(din);
            exp = sb.pop_front();
            tick();
            check($sformatf("wrap%0d valid", i), 32'(vld), 32'd1);
            check($sformatf("wrap%0d data", i), 32'(dout), 32'(exp));
        end
        rd = 1'b1;
        exp = sb.pop_front();
        tick();
        check("wrap last data", 32'(dout), 32'(exp));
        chk_state("wrap end", 3'd0, 6'b001100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
